// File: rtl/ds_pkg.sv
// Common constants for the lib_ds stream fabric.
//   DS_UPSIZE_MAX_RATIO : largest beats-per-word ratio ds_upsize accepts.
package ds_pkg;

  localparam int DS_UPSIZE_MAX_RATIO = 64;

endpackage

// File: rtl/sys_pkg_fn.sv
// Shared elaboration-time helper functions for the lib_ds fabric.
//   sclog2(n) : ceil(log2(n)), never less than 1, so that a counter
//               or index derived from it always has at least one bit.
package sys_pkg_fn;

  function automatic int sclog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ds_if.sv
// Valid/ready stream link for the lib_ds fabric.
//   data : payload, W bits
//   vld  : source has a beat on data
//   rdy  : sink can take a beat this cycle
//   xfer : vld && rdy, the cycle a beat actually moves
// Modports: mst drives data/vld, slv drives rdy.
interface ds_if #(
  parameter int W = 8
) ();

  logic [W-1:0] data;
  logic         vld;
  logic         rdy;
  logic         xfer;

  assign xfer = vld && rdy;

  modport mst (output data, output vld, input rdy, input xfer);
  modport slv (input data, input vld, input xfer, output rdy);

endinterface

// File: rtl/ds_upsize.sv
// Width up-converter: packs RATIO consecutive narrow beats into one wide
// word, lane 0 being the first beat received. A flush request emits a
// partially filled word together with its lane count.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : synchronous active-low reset
//   if_in    : narrow input stream, $bits(DTYPE) wide (slave side)
//   if_out   : wide output stream, RATIO*$bits(DTYPE) wide (master side);
//              lane k sits at bits [k*W +: W]
//   i_flush  : single-cycle request to emit the current partial word
//   o_cnt    : number of valid lanes in if_out.data, qualified by if_out.vld
module ds_upsize
  import sys_pkg_fn::*;
  import ds_pkg::*;
#(
  parameter type DTYPE = logic [7:0],
  parameter int  RATIO = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  ds_if.slv                            if_in,
  ds_if.mst                            if_out,
  input  logic                         i_flush,
  output logic [sclog2(RATIO+1)-1:0]   o_cnt
);

  localparam int W  = $bits(DTYPE);
  localparam int LW = RATIO * W;
  localparam int IW = sclog2(RATIO);
  localparam int CW = sclog2(RATIO + 1);

  localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RATIO);

  if (RATIO < 1 || RATIO > DS_UPSIZE_MAX_RATIO) begin : g_ratio_chk
    $error("ds_upsize: RATIO=%0d outside 1..%0d", RATIO, DS_UPSIZE_MAX_RATIO);
  end

  logic [IW-1:0] q_idx;
  logic [LW-1:0] q_acc;
  logic [LW-1:0] q_out_data;
  logic          q_out_vld;
  logic [CW-1:0] q_cnt;
  logic          q_flush_pend;

  DTYPE          beat;
  logic          slot_free;
  logic          in_rdy;
  logic          in_xfer;
  logic [LW-1:0] acc_next;
  logic [CW-1:0] fill;
  logic          full_load;
  logic          flush_hit;
  logic          flush_load;
  logic          pend_set;

  assign beat    = if_in.data;
  assign in_xfer = if_in.xfer;

  // Handshake: a word in progress keeps accumulating while the output is
  // stalled; only the completing lane needs a free output slot. A pending
  // flush freezes the partial word so its content cannot change before it
  // is emitted.
  always_comb begin
    slot_free = !q_out_vld || if_out.rdy;
    in_rdy    = !q_flush_pend && ((q_idx != LAST_IDX) || slot_free);
  end

  assign if_in.rdy = in_rdy;

  // Accumulator view including any beat accepted this cycle. Lanes at or
  // above the fill point are always zero because q_acc is cleared on
  // every load, so a partial word needs no extra masking.
  always_comb begin
    acc_next = q_acc;
    if (in_xfer) begin
      acc_next[int'(q_idx) * W +: W] = beat;
    end
  end

  always_comb begin
    fill       = CW'(q_idx) + CW'(in_xfer);
    full_load  = in_xfer && (q_idx == LAST_IDX);
    // A flush arriving with the completing beat is absorbed by that word.
    flush_hit  = (i_flush || q_flush_pend) && !full_load && (fill != '0);
    flush_load = flush_hit && slot_free;
    pend_set   = flush_hit && !slot_free;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      q_idx        <= '0;
      q_acc        <= '0;
      q_out_data   <= '0;
      q_out_vld    <= 1'b0;
      q_cnt        <= '0;
      q_flush_pend <= 1'b0;
    end else begin
      if (if_out.xfer) begin
        q_out_vld <= 1'b0;
      end

      if (full_load || flush_load) begin
        q_out_data   <= acc_next;
        q_out_vld    <= 1'b1;
        q_cnt        <= full_load ? FULL_CNT : fill;
        q_idx        <= '0;
        q_acc        <= '0;
        q_flush_pend <= 1'b0;
      end else begin
        if (in_xfer) begin
          q_idx <= q_idx + 1'b1;
          q_acc <= acc_next;
        end
        if (pend_set) begin
          q_flush_pend <= 1'b1;
        end
      end
    end
  end

  assign if_out.data = q_out_data;
  assign if_out.vld  = q_out_vld;
  assign o_cnt       = q_cnt;

endmodule

// File: tb/tb_ds_upsize.sv
// Bench for ds_upsize with RATIO=4 and byte beats. A queue-based model of
// the packing/flush rules predicts the output word sequence; directed
// sequences add literal expectations on timing and content.
module tb_ds_upsize;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int LW = W * R;
  localparam int CW = 3;

  typedef struct packed {
    logic [LW-1:0] data;
    logic [CW-1:0] cnt;
  } word_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [CW-1:0] cnt;

  ds_if #(.W(W))  in_if ();
  ds_if #(.W(LW)) out_if ();

  always #5 clk = ~clk;

  ds_upsize #(.DTYPE(logic [7:0]), .RATIO(R)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .if_in   (in_if),
    .if_out  (out_if),
    .i_flush (flush),
    .o_cnt   (cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: beats accepted so far in the current word, and words owed.
  logic [7:0] acc_q[$];
  word_t      exp_q[$];
  word_t      exp_w;
  bit         prev_stall;
  logic [LW-1:0] prev_data;
  logic [CW-1:0] prev_cnt;

  function automatic word_t pack_acc();
    word_t w;
    w.data = '0;
    foreach (acc_q[i]) w.data[i*W +: W] = acc_q[i];
    w.cnt = CW'(acc_q.size());
    return w;
  endfunction

  // Sampled on the falling edge: shows what the next rising edge acts on.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_data", out_if.data, prev_data);
        check("hold_cnt", cnt, prev_cnt);
      end
      if (out_if.vld && out_if.rdy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h cnt %0d, expected no word", out_if.data, cnt);
        end else begin
          exp_w = exp_q.pop_front();
          check("model_data", out_if.data, exp_w.data);
          check("model_cnt", cnt, exp_w.cnt);
        end
      end
      prev_stall = out_if.vld && !out_if.rdy;
      prev_data  = out_if.data;
      prev_cnt   = cnt;

      if (in_if.vld && in_if.rdy) acc_q.push_back(in_if.data);
      if (acc_q.size() == R) begin
        exp_q.push_back(pack_acc());
        acc_q.delete();
      end else if (flush && acc_q.size() > 0) begin
        exp_q.push_back(pack_acc());
        acc_q.delete();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat; returns 1 time unit after the edge that took it.
  task automatic send(input logic [7:0] d);
    int t;
    in_if.vld  = 1'b1;
    in_if.data = d;
    t = 0;
    @(negedge clk);
    while (!in_if.rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: beat 0x%0h not accepted, expected accept within 50 cycles", d);
    end
    @(posedge clk);
    #1;
    in_if.vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    in_if.vld  = 1'b0;
    in_if.data = '0;
    out_if.rdy = 1'b1;
    flush      = 1'b0;
    rst_n      = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_vld", out_if.vld, 1'b0);
    check("rst_data", out_if.data, 32'h0);
    check("rst_cnt", cnt, 3'd0);
    rst_n = 1'b1;
    check("rst_in_rdy", in_if.rdy, 1'b1);

    // Continuous stream 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      send(8'(i));
      check("stream_in_rdy", in_if.rdy, 1'b1);
      if (i == 3 || i == 7) check("stream_no_vld", out_if.vld, 1'b0);
      if (i == 4) begin
        check("stream_w0_vld", out_if.vld, 1'b1);
        check("stream_w0_data", out_if.data, 32'h04030201);
        check("stream_w0_cnt", cnt, 3'd4);
      end
      if (i == 8) begin
        check("stream_w1_vld", out_if.vld, 1'b1);
        check("stream_w1_data", out_if.data, 32'h08070605);
        check("stream_w1_cnt", cnt, 3'd4);
      end
    end

    // Output stall: accumulation continues until the last lane
    out_if.rdy = 1'b0;
    send(8'h11);
    check("stall_rdy_idx1", in_if.rdy, 1'b1);
    send(8'h12);
    check("stall_rdy_idx2", in_if.rdy, 1'b1);
    send(8'h13);
    check("stall_rdy_idx3", in_if.rdy, 1'b0);
    in_if.vld  = 1'b1;
    in_if.data = 8'h14;
    tick();
    tick();
    check("stall_rdy_held", in_if.rdy, 1'b0);
    check("stall_data_held", out_if.data, 32'h08070605);
    out_if.rdy = 1'b1;
    tick();
    in_if.vld = 1'b0;
    check("stall_w_vld", out_if.vld, 1'b1);
    check("stall_w_data", out_if.data, 32'h14131211);
    check("stall_w_cnt", cnt, 3'd4);
    tick();
    check("stall_vld_drop", out_if.vld, 1'b0);

    // Flush of a two-lane partial word
    send(8'hAA);
    send(8'hBB);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_vld", out_if.vld, 1'b1);
    check("flush_data", out_if.data, 32'h0000BBAA);
    check("flush_cnt", cnt, 3'd2);
    tick();
    send(8'hCC);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_lane0_data", out_if.data, 32'h000000CC);
    check("flush_lane0_cnt", cnt, 3'd1);
    tick();

    // Flush while the output slot is busy
    out_if.rdy = 1'b0;
    send(8'h21);
    send(8'h22);
    send(8'h23);
    send(8'h24);
    send(8'h55);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("pend_in_rdy", in_if.rdy, 1'b0);
    tick();
    check("pend_in_rdy_held", in_if.rdy, 1'b0);
    check("pend_w_data", out_if.data, 32'h24232221);
    out_if.rdy = 1'b1;
    tick();
    check("pend_flush_vld", out_if.vld, 1'b1);
    check("pend_flush_data", out_if.data, 32'h00000055);
    check("pend_flush_cnt", cnt, 3'd1);
    check("pend_in_rdy_back", in_if.rdy, 1'b1);
    tick();
    check("pend_vld_drop", out_if.vld, 1'b0);

    // Flush coinciding with the completing beat
    send(8'h31);
    send(8'h32);
    send(8'h33);
    in_if.vld  = 1'b1;
    in_if.data = 8'h34;
    flush      = 1'b1;
    tick();
    in_if.vld = 1'b0;
    flush     = 1'b0;
    check("absorb_data", out_if.data, 32'h34333231);
    check("absorb_cnt", cnt, 3'd4);
    tick();
    check("absorb_no_extra", out_if.vld, 1'b0);
    tick();
    check("absorb_no_extra2", out_if.vld, 1'b0);

    // Flush with nothing accumulated
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("empty_flush_vld", out_if.vld, 1'b0);
    tick();
    check("empty_flush_vld2", out_if.vld, 1'b0);

    // Reset mid-word
    send(8'h41);
    send(8'h42);
    send(8'h43);
    rst_n = 1'b0;
    tick();
    check("midrst_vld", out_if.vld, 1'b0);
    check("midrst_cnt", cnt, 3'd0);
    check("midrst_in_rdy", in_if.rdy, 1'b1);
    rst_n = 1'b1;
    send(8'h51);
    send(8'h52);
    send(8'h53);
    send(8'h54);
    check("midrst_w_data", out_if.data, 32'h54535251);
    check("midrst_w_cnt", cnt, 3'd4);
    tick();
    tick();

    check("end_exp_empty", 64'(exp_q.size()), 64'd0);
    check("end_acc_empty", 64'(acc_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
